// File: rtl/fll_pkg.sv
// Shared types and default widths for the FLL lock detector and the FLL core error output.
package fll_pkg;

  localparam int FLL_EW = 9;
  localparam int FLL_CW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2,
    HOLD = 2'd3
  } fll_lock_state_t;

endpackage

// File: rtl/fll_lock_det.sv
// FLL lock detector: hysteretic lock flag from per-window signed frequency error.
// Optional FLL_LOCK_STATS_EN adds a saturating loss counter and the last in-tolerance result.
module fll_lock_det
  import fll_pkg::*;
#(
  parameter int EW = FLL_EW,
  parameter int CW = FLL_CW
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 err_vld_i,
  input  logic signed [EW-1:0] err_i,
  input  logic        [EW-2:0] tol_i,
  input  logic        [CW-1:0] acq_cnt_i,
  input  logic        [CW-1:0] los_cnt_i,
  output logic                 lock_o,
  output logic                 lost_o,
  output logic        [1:0]    state_o
`ifdef FLL_LOCK_STATS_EN
  ,
  output logic        [CW-1:0] lost_cnt_o,
  output logic                 in_tol_o
`endif
);

  fll_lock_state_t state;
  logic [CW-1:0]   cnt;

  logic [EW-1:0] err_u;
  logic [EW-1:0] mag;
  logic          in_tol;
  logic [CW-1:0] acq_thr;
  logic [CW-1:0] los_thr;
  logic [CW:0]   cnt_ext;
  logic [CW-1:0] cnt_sat;
  logic          acq_hit;
  logic          los_hit;
  logic          lose_now;

  // EW-bit unsigned magnitude: the most negative code maps onto 2^(EW-1) without overflow.
  assign err_u  = $unsigned(err_i);
  assign mag    = err_u[EW-1] ? (~err_u + 1'b1) : err_u;
  assign in_tol = (mag <= {1'b0, tol_i});

  assign acq_thr = (acq_cnt_i == '0) ? CW'(1) : acq_cnt_i;
  assign los_thr = (los_cnt_i == '0) ? CW'(1) : los_cnt_i;

  assign cnt_ext = {1'b0, cnt} + 1'b1;
  assign cnt_sat = (&cnt) ? cnt : cnt_ext[CW-1:0];
  assign acq_hit = (cnt_ext >= {1'b0, acq_thr});
  assign los_hit = (cnt_ext >= {1'b0, los_thr});

  assign lose_now = en_i && err_vld_i && !in_tol &&
                    (((state == LOCK) && (los_thr == CW'(1))) ||
                     ((state == HOLD) && los_hit));

  assign state_o = state;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      cnt    <= '0;
      lock_o <= 1'b0;
      lost_o <= 1'b0;
    end else begin
      lost_o <= 1'b0;
      if (!en_i) begin
        state  <= IDLE;
        cnt    <= '0;
        lock_o <= 1'b0;
      end else if (lose_now) begin
        // A loss always restarts acquisition from an empty run.
        state  <= ACQ;
        cnt    <= '0;
        lock_o <= 1'b0;
        lost_o <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            state <= ACQ;
            cnt   <= '0;
          end
          ACQ: begin
            if (err_vld_i) begin
              if (!in_tol) begin
                cnt <= '0;
              end else if (acq_hit) begin
                state  <= LOCK;
                cnt    <= '0;
                lock_o <= 1'b1;
              end else begin
                cnt <= cnt_sat;
              end
            end
          end
          LOCK: begin
            if (err_vld_i && !in_tol) begin
              state <= HOLD;
              cnt   <= CW'(1);
            end
          end
          HOLD: begin
            if (err_vld_i) begin
              if (in_tol) begin
                state <= LOCK;
                cnt   <= '0;
              end else begin
                cnt <= cnt_sat;
              end
            end
          end
          default: begin
            state  <= IDLE;
            cnt    <= '0;
            lock_o <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef FLL_LOCK_STATS_EN
  logic accept;

  assign accept = en_i && err_vld_i && (state != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lost_cnt_o <= '0;
      in_tol_o   <= 1'b0;
    end else begin
      if (lose_now && !(&lost_cnt_o)) lost_cnt_o <= lost_cnt_o + 1'b1;
      if (accept) in_tol_o <= in_tol;
    end
  end
`endif

endmodule

// File: tb/tb_fll_lock_det.sv
// Self-checking bench for fll_lock_det: directed scenarios plus randomized run against a run-length model.
module tb_fll_lock_det;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              en_i = 1'b0;
  logic              err_vld_i = 1'b0;
  logic signed [8:0] err_i = '0;
  logic [7:0]        tol_i = '0;
  logic [7:0]        acq_cnt_i = 8'd1;
  logic [7:0]        los_cnt_i = 8'd1;
  logic              lock_o;
  logic              lost_o;
  logic [1:0]        state_o;
`ifdef FLL_LOCK_STATS_EN
  logic [7:0]        lost_cnt_o;
  logic              in_tol_o;
`endif

  int total = 0;
  int bad = 0;

  // Reference model: whether the detector is running, locked, and the current good/bad run lengths.
  bit m_active = 0;
  bit m_locked = 0;
  bit m_lost = 0;
  int m_good = 0;
  int m_bad = 0;
  int m_lost_cnt = 0;
  bit m_in_tol = 0;

  fll_lock_det #(.EW(9), .CW(8)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (en_i),
    .err_vld_i (err_vld_i),
    .err_i     (err_i),
    .tol_i     (tol_i),
    .acq_cnt_i (acq_cnt_i),
    .los_cnt_i (los_cnt_i),
    .lock_o    (lock_o),
    .lost_o    (lost_o),
    .state_o   (state_o)
`ifdef FLL_LOCK_STATS_EN
    ,
    .lost_cnt_o(lost_cnt_o),
    .in_tol_o  (in_tol_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic int exp_state();
    if (!m_active) return 0;
    if (!m_locked) return 1;
    if (m_bad > 0) return 3;
    return 2;
  endfunction

  task automatic model_reset();
    m_active = 0; m_locked = 0; m_lost = 0; m_good = 0; m_bad = 0;
    m_lost_cnt = 0; m_in_tol = 0;
  endtask

  task automatic model_clock(input bit en, input bit vld, input int e, input int tol,
                             input int acq, input int los);
    int mag;
    int at;
    int lt;
    bit ok;
    mag = (e < 0) ? -e : e;
    ok  = (mag <= tol);
    at  = (acq == 0) ? 1 : acq;
    lt  = (los == 0) ? 1 : los;
    m_lost = 0;
    if (!en) begin
      m_active = 0; m_locked = 0; m_good = 0; m_bad = 0;
    end else if (!m_active) begin
      m_active = 1; m_good = 0; m_bad = 0;
    end else if (vld) begin
      m_in_tol = ok;
      if (!m_locked) begin
        if (ok) begin
          m_good++;
          if (m_good >= at) begin m_locked = 1; m_good = 0; end
        end else m_good = 0;
      end else if (ok) begin
        m_bad = 0;
      end else begin
        m_bad++;
        if (m_bad >= lt) begin
          m_locked = 0; m_bad = 0; m_good = 0; m_lost = 1;
          if (m_lost_cnt < 255) m_lost_cnt++;
        end
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model at the rising edge, settle 1 time unit.
  task automatic applyStimulus(input bit en, input bit vld, input int e);
    @(negedge clk_i);
    en_i = en; err_vld_i = vld; err_i = 9'(e);
    @(posedge clk_i);
    model_clock(en, vld, e, int'(tol_i), int'(acq_cnt_i), int'(los_cnt_i));
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    model_reset();
    @(negedge clk_i);
    en_i = 1'b0; err_vld_i = 1'b0;
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    tol_i = 8'd2; acq_cnt_i = 8'd1; los_cnt_i = 8'd3;
    applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 9);
    @(negedge clk_i);
    en_i = 1'b1; err_vld_i = 1'b1; err_i = 9'sd9;
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    total++; if (lock_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_lock got=%b want=0", lock_o); end
    total++; if (lost_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_lost got=%b want=0", lost_o); end
    total++; if (state_o !== 2'd0) begin bad++; $display("[TB] FAIL reset_state got=%0d want=0", state_o); end
    @(posedge clk_i); #1;
    total++; if (state_o !== 2'd0 || lock_o !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_held state=%0d lock=%b want 0/0", state_o, lock_o);
    end
    @(negedge clk_i);
    en_i = 1'b0; err_vld_i = 1'b0;
    rst_ni = 1'b1;
    applyStimulus(0, 0, 0);
    total++; if (lost_o !== 1'b0 || state_o !== 2'd0) begin
      bad++; $display("[TB] FAIL reset_release lost=%b state=%0d want 0/0", lost_o, state_o);
    end
  endtask

  task automatic test_acquire();
    int seq1[4] = '{1, -2, 0, 2};
    int seq2[4] = '{1, 1, 3, 0};
    tol_i = 8'd2; acq_cnt_i = 8'd4; los_cnt_i = 8'd3;
    applyStimulus(1, 0, 0);
    total++; if (state_o !== 2'd1) begin bad++; $display("[TB] FAIL acq_enter state=%0d want=1", state_o); end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, seq1[i]);
      total++; if (lock_o !== 1'b0) begin bad++; $display("[TB] FAIL acq_early%0d lock=%b want=0", i, lock_o); end
    end
    applyStimulus(1, 1, seq1[3]);
    total++; if (lock_o !== 1'b1 || state_o !== 2'd2) begin
      bad++; $display("[TB] FAIL acq_lock lock=%b state=%0d want 1/2", lock_o, state_o);
    end
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, seq2[i]);
    for (int i = 0; i < 2; i++) applyStimulus(1, 1, -1);
    total++; if (lock_o !== 1'b0) begin bad++; $display("[TB] FAIL acq_reset_run lock=%b want=0", lock_o); end
    applyStimulus(1, 1, 2);
    total++; if (lock_o !== 1'b1) begin bad++; $display("[TB] FAIL acq_after_bad lock=%b want=1", lock_o); end
  endtask

  task automatic test_hysteresis();
    int want_st[3] = '{3, 3, 2};
    los_cnt_i = 8'd3;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, (i == 2) ? 0 : 5);
      total++; if (state_o !== 2'(want_st[i]) || lock_o !== 1'b1 || lost_o !== 1'b0) begin
        bad++; $display("[TB] FAIL hyst_hold%0d state=%0d lock=%b lost=%b want %0d/1/0",
                        i, state_o, lock_o, lost_o, want_st[i]);
      end
    end
    applyStimulus(1, 1, 5);
    applyStimulus(1, 1, 5);
    total++; if (lock_o !== 1'b1 || lost_o !== 1'b0) begin
      bad++; $display("[TB] FAIL hyst_pre_loss lock=%b lost=%b want 1/0", lock_o, lost_o);
    end
    applyStimulus(1, 1, 5);
    total++; if (lock_o !== 1'b0 || lost_o !== 1'b1 || state_o !== 2'd1) begin
      bad++; $display("[TB] FAIL hyst_loss lock=%b lost=%b state=%0d want 0/1/1", lock_o, lost_o, state_o);
    end
    applyStimulus(1, 0, 0);
    total++; if (lost_o !== 1'b0) begin bad++; $display("[TB] FAIL hyst_pulse_width lost=%b want=0", lost_o); end
  endtask

  task automatic test_boundaries();
    tol_i = 8'd255; acq_cnt_i = 8'd1; los_cnt_i = 8'd1;
    applyStimulus(1, 1, -256);
    total++; if (lock_o !== 1'b0) begin bad++; $display("[TB] FAIL bnd_min_neg lock=%b want=0", lock_o); end
    applyStimulus(1, 1, -255);
    total++; if (lock_o !== 1'b1) begin bad++; $display("[TB] FAIL bnd_neg255 lock=%b want=1", lock_o); end
    los_cnt_i = 8'd0;
    applyStimulus(1, 1, -256);
    total++; if (lock_o !== 1'b0 || lost_o !== 1'b1) begin
      bad++; $display("[TB] FAIL bnd_los0 lock=%b lost=%b want 0/1", lock_o, lost_o);
    end
    tol_i = 8'd0; acq_cnt_i = 8'd0;
    applyStimulus(1, 1, 1);
    applyStimulus(1, 1, 0);
    total++; if (lock_o !== 1'b1) begin bad++; $display("[TB] FAIL bnd_acq0 lock=%b want=1", lock_o); end
  endtask

  task automatic test_enable_priority();
    tol_i = 8'd2; acq_cnt_i = 8'd2; los_cnt_i = 8'd2;
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(0, 1, 0);
    total++; if (state_o !== 2'd0 || lock_o !== 1'b0 || lost_o !== 1'b0) begin
      bad++; $display("[TB] FAIL en_prio state=%0d lock=%b lost=%b want 0/0/0", state_o, lock_o, lost_o);
    end
    applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 7);
    applyStimulus(0, 1, 7);
    total++; if (state_o !== 2'd0 || lock_o !== 1'b0 || lost_o !== 1'b0) begin
      bad++; $display("[TB] FAIL en_drop_hold state=%0d lock=%b lost=%b want 0/0/0", state_o, lock_o, lost_o);
    end
  endtask

  task automatic test_random();
    int e;
    bit en;
    bit vld;
    int errs = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        tol_i = 8'($urandom_range(0, 8));
        acq_cnt_i = 8'($urandom_range(0, 5));
        los_cnt_i = 8'($urandom_range(0, 5));
      end
      e = $urandom_range(0, 24) - 12;
      if ($urandom_range(0, 40) == 0) e = ($urandom_range(0, 1) == 0) ? -256 : 255;
      en  = ($urandom_range(0, 60) != 0);
      vld = ($urandom_range(0, 9) < 6);
      applyStimulus(en, vld, e);
      total++;
      if (lock_o !== m_locked || lost_o !== m_lost || state_o !== 2'(exp_state())) begin
        bad++; errs++;
        if (errs <= 10)
          $display("[TB] FAIL rand_cyc%0d lock=%b lost=%b state=%0d want %b/%b/%0d",
                   i, lock_o, lost_o, state_o, m_locked, m_lost, exp_state());
      end
`ifdef FLL_LOCK_STATS_EN
      total++;
      if (lost_cnt_o !== 8'(m_lost_cnt) || in_tol_o !== m_in_tol) begin
        bad++; errs++;
        if (errs <= 10)
          $display("[TB] FAIL rand_stats%0d cnt=%0d in_tol=%b want %0d/%b",
                   i, lost_cnt_o, in_tol_o, m_lost_cnt, m_in_tol);
      end
`endif
    end
  endtask

`ifdef FLL_LOCK_STATS_EN
  task automatic test_stats();
    do_reset();
    tol_i = 8'd2; acq_cnt_i = 8'd1; los_cnt_i = 8'd1;
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0);
      applyStimulus(1, 1, 9);
    end
    total++; if (lost_cnt_o !== 8'd3) begin bad++; $display("[TB] FAIL stats_three got=%0d want=3", lost_cnt_o); end
    for (int i = 0; i < 297; i++) begin
      applyStimulus(1, 1, 0);
      applyStimulus(1, 1, 9);
    end
    total++; if (lost_cnt_o !== 8'd255) begin bad++; $display("[TB] FAIL stats_sat got=%0d want=255", lost_cnt_o); end
    total++; if (in_tol_o !== 1'b0) begin bad++; $display("[TB] FAIL stats_in_tol got=%b want=0", in_tol_o); end
  endtask
`endif

  initial begin
    #1;
    model_reset();
    do_reset();
    test_reset();
    test_acquire();
    test_hysteresis();
    test_boundaries();
    test_enable_priority();
    test_random();
`ifdef FLL_LOCK_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
